// File: rtl/sdram_host_master_if.sv
// Client and SDRAM-controller host handshake bundle for sdram_host_master.
// master = burst initiator side, slave = client plus controller side.
interface sdram_host_master_if #(
    parameter int ASIZE  = 22,
    parameter int DSIZE  = 16,
    parameter int MAXLEN = 8
);
    logic                      C_REQ;
    logic                      C_WE;
    logic [ASIZE-1:0]          C_ADDR;
    logic [$clog2(MAXLEN):0]   C_LEN;
    logic [DSIZE-1:0]          C_WDATA;
    logic                      C_WPUSH;
    logic                      C_BUSY;
    logic [DSIZE-1:0]          C_RDATA;
    logic                      C_RVALID;
    logic                      C_DONE;
    logic                      C_ERR;

    logic [ASIZE-1:0]          ADDR;
    logic                      WR;
    logic                      RD;
    logic [7:0]                LENGTH;
    logic [DSIZE-1:0]          DATAIN;
    logic [DSIZE/8-1:0]        DM;
    logic [DSIZE-1:0]          DATAOUT;
    logic                      IN_REQ;
    logic                      OUT_VALID;
    logic                      DONE;
    logic                      ACT;

    modport master (
        input  C_REQ, C_WE, C_ADDR, C_LEN, C_WDATA, C_WPUSH,
        input  DATAOUT, IN_REQ, OUT_VALID, DONE, ACT,
        output C_BUSY, C_RDATA, C_RVALID, C_DONE, C_ERR,
        output ADDR, WR, RD, LENGTH, DATAIN, DM
    );

    modport slave (
        output C_REQ, C_WE, C_ADDR, C_LEN, C_WDATA, C_WPUSH,
        output DATAOUT, IN_REQ, OUT_VALID, DONE, ACT,
        input  C_BUSY, C_RDATA, C_RVALID, C_DONE, C_ERR,
        input  ADDR, WR, RD, LENGTH, DATAIN, DM
    );
endinterface

// File: rtl/sdram_host_master.sv
// Single-burst SDRAM host initiator: buffers one write burst, streams read words,
// and keeps the controller's WR/RD level-start / hold-until-DONE / gap rules.
//
// state  | meaning
// IDLE   | waiting for C_REQ, length checked on accept
// LOAD   | collecting write words into the burst buffer
// ISSUE  | WR/RD registered high on exit
// XFER   | request level held, data moving, DONE / timeout watched
// GAP    | WR/RD low for one cycle, C_DONE or C_ERR pulses
module sdram_host_master #(
    parameter int ASIZE   = 22,
    parameter int DSIZE   = 16,
    parameter int MAXLEN  = 8,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    sdram_host_master_if.master  bus
);
    localparam int PW = $clog2(MAXLEN);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] LEN_ONE = LW'(1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAXLEN);
    localparam logic [7:0]    TMO     = 8'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_XFER, S_GAP} state_t;

    state_t            state, state_n;
    logic              we_q;
    logic [LW-1:0]     len_q, lptr, rcnt;
    logic [PW-1:0]     wptr;
    logic              done_seen;
    logic [7:0]        tcnt;
    logic [RD_LAT-1:0] ov_pipe;
    logic [DSIZE-1:0]  wbuf [MAXLEN];

    logic len_bad, ov_dly, rd_take, push_ok;
    logic fin_ok, fin_abort, reject;
    logic act_unused;

    assign act_unused = bus.ACT;
    assign len_bad    = (bus.C_LEN == '0) || (bus.C_LEN > LEN_MAX);
    assign ov_dly     = ov_pipe[RD_LAT-1];
    assign rd_take    = (state == S_XFER) && !we_q && ov_dly && (rcnt < len_q);
    assign push_ok    = (state == S_LOAD) && bus.C_WPUSH;

    // Combinational so the word presented follows IN_REQ with no added latency.
    assign bus.DATAIN = wbuf[wptr];
    assign bus.DM     = '0;

    always_comb begin
        state_n   = state;
        fin_ok    = 1'b0;
        fin_abort = 1'b0;
        reject    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.C_REQ) begin
                    if (len_bad) reject = 1'b1;
                    else         state_n = bus.C_WE ? S_LOAD : S_ISSUE;
                end
            end
            S_LOAD: begin
                if (bus.C_WPUSH && ((lptr + LEN_ONE) == len_q)) state_n = S_ISSUE;
            end
            S_ISSUE: state_n = S_XFER;
            S_XFER: begin
                if (done_seen && (we_q || (rcnt == len_q))) begin
                    state_n = S_GAP;
                    fin_ok  = 1'b1;
                end else if ((tcnt + 8'd1) == TMO) begin
                    state_n   = S_GAP;
                    fin_abort = 1'b1;
                end
            end
            S_GAP:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= S_IDLE;
            we_q         <= 1'b0;
            len_q        <= '0;
            lptr         <= '0;
            rcnt         <= '0;
            wptr         <= '0;
            done_seen    <= 1'b0;
            tcnt         <= '0;
            ov_pipe      <= '0;
            bus.C_BUSY   <= 1'b0;
            bus.C_RDATA  <= '0;
            bus.C_RVALID <= 1'b0;
            bus.C_DONE   <= 1'b0;
            bus.C_ERR    <= 1'b0;
            bus.ADDR     <= '0;
            bus.LENGTH   <= '0;
            bus.WR       <= 1'b0;
            bus.RD       <= 1'b0;
        end else begin
            state        <= state_n;
            bus.C_BUSY   <= (state_n != S_IDLE);
            bus.WR       <= (state_n == S_XFER) && we_q;
            bus.RD       <= (state_n == S_XFER) && !we_q;
            bus.C_DONE   <= fin_ok;
            bus.C_ERR    <= fin_abort | reject;
            bus.C_RVALID <= rd_take;
            ov_pipe      <= (ov_pipe << 1) | RD_LAT'(bus.OUT_VALID);

            if (state == S_IDLE && bus.C_REQ) begin
                we_q       <= bus.C_WE;
                bus.ADDR   <= bus.C_ADDR;
                len_q      <= bus.C_LEN;
                bus.LENGTH <= 8'(bus.C_LEN);
                lptr       <= '0;
                wptr       <= '0;
                rcnt       <= '0;
            end
            if (push_ok) lptr <= lptr + LEN_ONE;
            if (state == S_ISSUE) begin
                tcnt      <= '0;
                done_seen <= 1'b0;
            end
            if (state == S_XFER) begin
                tcnt      <= tcnt + 8'd1;
                done_seen <= done_seen | bus.DONE;
                // Pointer parks on the last word once the burst is consumed.
                if (we_q && bus.IN_REQ && ({1'b0, wptr} != (len_q - LEN_ONE)))
                    wptr <= wptr + PW'(1);
            end
            if (rd_take) begin
                bus.C_RDATA <= bus.DATAOUT;
                rcnt        <= rcnt + LEN_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) wbuf[lptr[PW-1:0]] <= bus.C_WDATA;
    end
endmodule

// File: tb/tb_sdram_host_master.sv
// Bench for sdram_host_master: table of bursts driven through a client and
// controller model, with queued expected read/write words checked as they appear.
module tb_sdram_host_master;
    localparam int ASIZE   = 22;
    localparam int DSIZE   = 16;
    localparam int MAXLEN  = 8;
    localparam int TIMEOUT = 255;
    localparam int NV      = 10;

    typedef struct {
        bit          we;
        logic [21:0] addr;
        logic [3:0]  len;
        int          beats;
        bit          no_done;
        int          exp_rv;
        int          exp_done;
        int          exp_err;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    sdram_host_master_if #(.ASIZE(ASIZE), .DSIZE(DSIZE), .MAXLEN(MAXLEN)) bus();

    sdram_host_master #(
        .ASIZE(ASIZE), .DSIZE(DSIZE), .MAXLEN(MAXLEN), .RD_LAT(1), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    assign bus.ACT = bus.WR | bus.RD;

    int tests = 0, fails = 0;
    int n_rv = 0, n_done = 0, n_err = 0, n_wr = 0, n_rd = 0, n_busy = 0;
    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observe the cycle at the falling edge, then return 1ns after the next rising edge.
    task automatic tick();
        @(negedge CLK);
        if (bus.C_RVALID) begin
            n_rv++;
            if (rd_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL rdata_extra: got 0x%0h, expected no word", bus.C_RDATA);
            end else chk("rdata", bus.C_RDATA, rd_q.pop_front());
        end
        if (bus.IN_REQ && bus.WR) begin
            if (wr_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL datain_extra: got 0x%0h, expected no word", bus.DATAIN);
            end else chk("datain", bus.DATAIN, wr_q.pop_front());
        end
        n_done += int'(bus.C_DONE);
        n_err  += int'(bus.C_ERR);
        n_wr   += int'(bus.WR);
        n_rd   += int'(bus.RD);
        n_busy += int'(bus.C_BUSY);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_burst(input vec_t v);
        int b_rv, b_done, b_err, b_wr, b_rd, b_busy, k;
        bit bad;
        b_rv = n_rv; b_done = n_done; b_err = n_err;
        b_wr = n_wr; b_rd = n_rd; b_busy = n_busy;
        bad = (v.len == 0) || (v.len > MAXLEN);
        bus.C_REQ = 1'b1; bus.C_WE = v.we; bus.C_ADDR = v.addr; bus.C_LEN = v.len;
        tick();
        bus.C_REQ = 1'b0;
        if (bad) begin
            chk("reject_err", bus.C_ERR, 1);
            chk("reject_busy", bus.C_BUSY, 0);
            repeat (4) tick();
            chk("reject_wrrd_cycles", (n_wr - b_wr) + (n_rd - b_rd), 0);
            chk("reject_busy_cycles", n_busy - b_busy, 0);
        end else begin
            chk("accept_busy", bus.C_BUSY, 1);
            chk("addr", bus.ADDR, v.addr);
            chk("length", bus.LENGTH, v.len);
            if (v.we) begin
                for (int i = 0; i < int'(v.len); i++) begin
                    chk("wr_early", bus.WR, 0);
                    bus.C_WDATA = 16'((i + 1) * 16'h1111);
                    bus.C_WPUSH = 1'b1;
                    wr_q.push_back(bus.C_WDATA);
                    tick();
                end
                bus.C_WPUSH = 1'b0;
                chk("wr_after_last_push", bus.WR, 0);
                tick();
                chk("wr_rise", bus.WR, 1);
                chk("dm", bus.DM, 0);
                for (int i = 0; i < int'(v.len); i++) begin
                    bus.IN_REQ = 1'b1;
                    tick();
                end
                bus.IN_REQ = 1'b0;
            end else begin
                chk("rd_pre", bus.RD, 0);
                tick();
                chk("rd_rise", bus.RD, 1);
                tick();
                // RD_LAT=1: the word belonging to OUT_VALID cycle i is on DATAOUT in cycle i+1.
                for (int i = 0; i <= v.beats; i++) begin
                    bus.OUT_VALID = (i < v.beats);
                    bus.DATAOUT   = (i > 0) ? 16'(16'h00A0 + i - 1) : 16'h0000;
                    if (i < v.beats && i < int'(v.len)) rd_q.push_back(16'(16'h00A0 + i));
                    tick();
                end
                bus.OUT_VALID = 1'b0;
                bus.DATAOUT   = 16'h0000;
            end
            bus.DONE = !v.no_done;
            tick();
            bus.DONE = 1'b0;
            k = 0;
            while (!bus.C_DONE && !bus.C_ERR && k < 400) begin
                tick();
                k++;
            end
            chk("finish_seen", bus.C_DONE | bus.C_ERR, 1);
            chk("gap_wrrd", bus.WR | bus.RD, 0);
            chk("gap_busy", bus.C_BUSY, 1);
            tick();
            chk("idle_busy", bus.C_BUSY, 0);
            if (v.no_done) chk("timeout_rd_cycles", n_rd - b_rd, TIMEOUT);
        end
        chk("rvalid_count", n_rv - b_rv, v.exp_rv);
        chk("done_count", n_done - b_done, v.exp_done);
        chk("err_count", n_err - b_err, v.exp_err);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.C_REQ = 0; bus.C_WE = 0; bus.C_ADDR = '0; bus.C_LEN = '0;
        bus.C_WDATA = '0; bus.C_WPUSH = 0; bus.DATAOUT = '0;
        bus.IN_REQ = 0; bus.OUT_VALID = 0; bus.DONE = 0;

        //          we    addr          len   beats nodone rv done err
        vecs[0] = '{1'b0, 22'h000100, 4'd4, 4, 1'b0, 4, 1, 0};
        vecs[1] = '{1'b1, 22'h002000, 4'd8, 0, 1'b0, 0, 1, 0};
        vecs[2] = '{1'b0, 22'h000300, 4'd0, 0, 1'b0, 0, 0, 1};
        vecs[3] = '{1'b0, 22'h000400, 4'd9, 0, 1'b0, 0, 0, 1};
        vecs[4] = '{1'b0, 22'h000500, 4'd2, 4, 1'b0, 2, 1, 0};
        vecs[5] = '{1'b1, 22'h000600, 4'd1, 0, 1'b0, 0, 1, 0};
        vecs[6] = '{1'b0, 22'h000700, 4'd8, 8, 1'b0, 8, 1, 0};
        vecs[7] = '{1'b0, 22'h000800, 4'd2, 2, 1'b1, 2, 0, 1};
        vecs[8] = '{1'b0, 22'h000900, 4'd3, 3, 1'b0, 3, 1, 0};
        vecs[9] = '{1'b1, 22'h000A00, 4'd0, 0, 1'b0, 0, 0, 1};

        repeat (2) tick();
        chk("rst_busy",   bus.C_BUSY, 0);
        chk("rst_wr",     bus.WR, 0);
        chk("rst_rd",     bus.RD, 0);
        chk("rst_rvalid", bus.C_RVALID, 0);
        chk("rst_done",   bus.C_DONE, 0);
        chk("rst_err",    bus.C_ERR, 0);
        chk("rst_rdata",  bus.C_RDATA, 0);
        chk("rst_addr",   bus.ADDR, 0);
        chk("rst_length", bus.LENGTH, 0);
        RESET_N = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) run_burst(vecs[i]);

        // Reset in the middle of a write transfer, then an immediate new request.
        bus.C_REQ = 1'b1; bus.C_WE = 1'b1; bus.C_ADDR = 22'h3ABCD; bus.C_LEN = 4'd8;
        tick();
        bus.C_REQ = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.C_WDATA = 16'((i + 1) * 16'h1111);
            bus.C_WPUSH = 1'b1;
            wr_q.push_back(bus.C_WDATA);
            tick();
        end
        bus.C_WPUSH = 1'b0;
        tick();
        chk("mid_wr_high", bus.WR, 1);
        bus.IN_REQ = 1'b1;
        repeat (3) tick();
        RESET_N = 1'b0;
        bus.IN_REQ = 1'b0;
        #1;
        chk("mid_rst_wr",     bus.WR, 0);
        chk("mid_rst_busy",   bus.C_BUSY, 0);
        chk("mid_rst_addr",   bus.ADDR, 0);
        chk("mid_rst_length", bus.LENGTH, 0);
        chk("mid_rst_rdata",  bus.C_RDATA, 0);
        chk("mid_rst_rd",     bus.RD, 0);
        chk("mid_rst_pulses", {bus.C_RVALID, bus.C_DONE, bus.C_ERR}, 0);
        chk("mid_rst_words_left", wr_q.size(), 5);
        wr_q.delete();
        tick();
        RESET_N = 1'b1;
        run_burst(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
